// File: rtl/lc3b_types.sv
// Shared types for the LC-3b cache controller slice.
package lc3b_types;

    // Sequencer states of the cache controller.
    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } lc3b_cache_state_t;

    localparam int unsigned DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
module sat_counter #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [width-1:0] count
);

    // Count up on inc, hold at all-ones, clear to zero on request.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way, 8-set write-back cache datapath.
//
// state     | meaning
// ----------+--------------------------------------------------------
// CHECK     | tag compare; serve hits, pick victim on a miss
// WRITEBACK | write dirty victim line to memory, wait for mem_resp
// ALLOCATE  | read line from memory, fill victim way on mem_resp
module cache_control
    import lc3b_types::*;
#(
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cache_read,
    input  logic                 cache_write,
    output logic                 cache_resp,
    input  logic                 way1_hit,
    input  logic                 way2_hit,
    input  logic                 LRU_out,
    input  logic                 dirty_1,
    input  logic                 dirty_2,
    output logic                 R_W,
    output logic                 load_data_1,
    output logic                 load_data_2,
    output logic                 load_dirty_1,
    output logic                 load_dirty_2,
    output logic                 dirty_bit,
    output logic                 load_LRU,
    output logic                 LRU_in,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_resp,
    input  logic                 perf_clear,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    lc3b_cache_state_t state, state_next;
    logic miss_pending;

    logic req;
    logic hit;
    logic hit_w1;
    logic victim_dirty;
    logic in_check;
    logic miss_evt;
    logic hit_evt;
    logic wb_evt;
    logic cnt_clear;

    // Way 1 wins when both ways report a hit; a simultaneous read+write is a write.
    assign req          = cache_read | cache_write;
    assign hit          = way1_hit | way2_hit;
    assign hit_w1       = way1_hit;
    assign victim_dirty = LRU_out ? dirty_2 : dirty_1;
    assign in_check     = (state == CHECK);
    assign miss_evt     = in_check & req & ~hit;
    assign wb_evt       = miss_evt & victim_dirty;
    assign hit_evt      = in_check & req & hit & ~miss_pending;
    assign cnt_clear    = reset | perf_clear;

    // Strobes and next state; everything is held at zero while reset is high.
    always_comb begin
        state_next   = state;
        cache_resp   = 1'b0;
        R_W          = 1'b0;
        load_data_1  = 1'b0;
        load_data_2  = 1'b0;
        load_dirty_1 = 1'b0;
        load_dirty_2 = 1'b0;
        dirty_bit    = 1'b0;
        load_LRU     = 1'b0;
        LRU_in       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        if (!reset) begin
            case (state)
                CHECK: begin
                    if (req) begin
                        if (hit) begin
                            cache_resp = 1'b1;
                            load_LRU   = 1'b1;
                            LRU_in     = hit_w1;
                            if (cache_write) begin
                                R_W          = 1'b1;
                                dirty_bit    = 1'b1;
                                load_data_1  = hit_w1;
                                load_dirty_1 = hit_w1;
                                load_data_2  = ~hit_w1;
                                load_dirty_2 = ~hit_w1;
                            end
                        end else begin
                            state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    mem_write = 1'b1;
                    R_W       = 1'b1;
                    if (mem_resp) begin
                        state_next = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        // LRU is not touched during the miss, so LRU_out still names the victim.
                        load_data_1  = ~LRU_out;
                        load_dirty_1 = ~LRU_out;
                        load_data_2  = LRU_out;
                        load_dirty_2 = LRU_out;
                        state_next   = CHECK;
                    end
                end
                default: state_next = CHECK;
            endcase
        end
    end

    // State register and the flag that keeps a missed request from also counting as a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CHECK;
            miss_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (miss_evt) begin
                miss_pending <= 1'b1;
            end else if (in_check && (cache_resp || !req)) begin
                miss_pending <= 1'b0;
            end
        end
    end

    sat_counter #(.width(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .clear (cnt_clear),
        .inc   (hit_evt),
        .count (hit_count)
    );

    sat_counter #(.width(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .clear (cnt_clear),
        .inc   (miss_evt),
        .count (miss_count)
    );

    sat_counter #(.width(CNT_WIDTH)) u_wb_cnt (
        .clk   (clk),
        .clear (cnt_clear),
        .inc   (wb_evt),
        .count (wb_count)
    );

endmodule
